shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one W-bit storage register, built from dff cells, among N requesters. A requester raises REQ, waits for its GNT bit, then writes the shared register through its own WE/WDATA lanes until it drops REQ. An optional hold limit forces rotation so that no requester can starve the others. The block sits between requester logic and the shared register, and it is the only block that sequences writes into that register.

Parameters:
N, 4, number of requesters (N >= 2)
W, 8, shared register width
MAX_HOLD, 4, maximum consecutive grant cycles per owner; 0 disables the limit
IDW, clog2(N), width of GNT_ID (derived; not overridden)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
REQ  input  N  request, one bit per requester
WE  input  N  write enable, one bit per requester
WDATA  input  N*W  write data; requester i owns bits [i*W+W-1 : i*W]
GNT  output  N  one-hot grant, registered
GNT_ID  output  IDW  index of the current owner; valid when BUSY=1
Q  output  W  shared register contents
BUSY  output  1  1 when any grant is active (state GRANT)

Behaviour:
- Reset: RST=1 clears all state immediately, with no clock edge required.
  - GNT=0, GNT_ID=0, Q=0, BUSY=0.
  - Internal state: PTR=0, HOLD=0, state=IDLE.
  - Reset asserted mid-grant or mid-write drops the owner. No write completes.
- States: IDLE and GRANT.
- IDLE:
  - If REQ != 0 at a rising edge, pick the first set bit searching circularly from PTR.
  - Set GNT one-hot, GNT_ID, BUSY=1, HOLD=0, and go to GRANT.
  - Grant latency is 1 cycle from REQ sampled to GNT visible.
- GRANT, owner i:
  - Write: if REQ[i]=1 and WE[i]=1 at an edge, Q <= WDATA slice i. Q is visible the cycle after the edge.
  - WE from any non-owner is ignored, and so is WE[i] while REQ[i]=0.
  - HOLD increments each edge the owner stays.
- Release: REQ[i]=0 at an edge.
  - Search REQ circularly from i+1.
  - If a requester is found, hand off directly: the new GNT appears at the same edge, there is no idle cycle, and HOLD=0.
  - If none is found: state=IDLE, GNT=0, BUSY=0, PTR=(i+1) mod N.
- Expiry: MAX_HOLD != 0, HOLD == MAX_HOLD-1 and REQ[i]=1 at an edge.
  - The owner's write at that edge still completes.
  - Hand off by searching from i+1. Owner i is considered last, so it is regranted only if it is the sole requester.
  - HOLD=0 on every handoff, including a regrant.
- Search wrap: index N-1 wraps to 0. PTR updates only when entering IDLE. In GRANT, search always starts at owner+1.
- GNT is always one-hot or zero. GNT_ID holds its last value in IDLE.
- Simultaneous events: release and expiry at the same edge are treated as release. At a handoff edge, a write from the new owner is not performed; writes are accepted only after GNT is visible.
- Q holds its value when no write occurs and is never cleared except by RST.

Decomposition:
- Shared package contains:
  - state encoding constants: IDLE=1'b0, GRANT=1'b1;
  - a clog2 helper for IDW.
- Sub-module rr_pick, combinational.
  - Inputs: REQ, START index, N.
  - Outputs: one-hot PICK, PICK_ID, FOUND.
  - Implements the rotating priority search. It is instantiated once, with START muxed between PTR (in IDLE) and owner+1 (in GRANT).
- The top level holds the state register, HOLD counter, PTR, GNT register and Q register.

Test Plan:
1. N=4, W=8, MAX_HOLD=4. Grant owner 2, then assert RST between clock edges -> GNT=0000, Q=00, BUSY=0 immediately. After RST is released, REQ=0001 -> GNT=0001 one edge later (PTR=0).
2. Single request: REQ=0100 sampled at edge k -> GNT=0100, GNT_ID=2, BUSY=1 after edge k. Then WE[2]=1 with slice 2=8'hA5 -> Q=A5 after edge k+1.
3. After reset, REQ=1111. Each owner writes once (slice value = 8'h10+i) then drops REQ -> GNT sequence 0001, 0010, 0100, 1000 with no GNT=0 cycle between owners. Final Q=13, then IDLE with PTR=0.
4. REQ=0011 held continuously, no WE -> GNT=0001 for 4 cycles, 0010 for 4, then 0001 for 4. BUSY stays 1 throughout.
5. Owner is 1 with WE[1]=0; non-owner has WE[3]=1, WDATA slice 3=8'hFF -> Q unchanged. Owner 1 drops REQ with WE[1]=1 at the same edge -> no write.
6. REQ=0001 held alone for 10 cycles -> GNT stays 0001, regranted at each expiry (HOLD restarts every 4 cycles), no glitch to 0000.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// state encoding and the width helper used to size GNT_ID and the hold counter.
package shared_reg_arbiter_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    // Minimum of 1 so a single-bit field is still produced for tiny values.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Rotating-priority search: returns the first set REQ bit at or after START,
// wrapping from N-1 back to 0.
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   REQ,
    input  logic [IDW-1:0] START,
    output logic [N-1:0]   PICK,
    output logic [IDW-1:0] PICK_ID,
    output logic           FOUND
);

    int idx;

    always_comb begin
        PICK    = '0;
        PICK_ID = '0;
        FOUND   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(START) + k) % N;
            if (!FOUND && REQ[idx]) begin
                FOUND   = 1'b1;
                PICK    = N'(1) << idx;
                PICK_ID = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that sequences writes from N requesters into one shared
// W-bit register, with an optional hold limit that forces rotation.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4,
    localparam int IDW     = clog2(N)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     REQ,
    input  logic [N-1:0]     WE,
    input  logic [N*W-1:0]   WDATA,
    output logic [N-1:0]     GNT,
    output logic [IDW-1:0]   GNT_ID,
    output logic [W-1:0]     Q,
    output logic             BUSY
);

    localparam int HW = clog2(MAX_HOLD + 2);

    logic           state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [W-1:0]   q_q, q_d;

    logic [IDW-1:0] start;
    logic [IDW-1:0] owner_nxt;
    logic [N-1:0]   pick;
    logic [IDW-1:0] pick_id;
    logic           found;
    logic           own_req;
    logic           own_we;
    logic [W-1:0]   own_wdata;
    logic           expire;

    assign owner_nxt = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
    assign start     = (state_q == IDLE) ? ptr_q : owner_nxt;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .REQ     (REQ),
        .START   (start),
        .PICK    (pick),
        .PICK_ID (pick_id),
        .FOUND   (found)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            q_q      <= q_d;
        end
    end

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_id_q == IDW'(i)) begin
                own_req   = REQ[i];
                own_we    = WE[i];
                own_wdata = WDATA[i*W +: W];
            end
        end
    end

    assign expire = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        q_d      = q_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d  = GRANT;
                gnt_d    = pick;
                gnt_id_d = pick_id;
                hold_d   = '0;
            end
        end else begin
            // Only the current owner can write; a new owner waits until GNT is visible.
            if (own_req && own_we) q_d = own_wdata;
            if (!own_req || expire) begin
                if (found) begin
                    gnt_d    = pick;
                    gnt_id_d = pick_id;
                    hold_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_nxt;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        GNT    = gnt_q;
        GNT_ID = gnt_id_q;
        Q      = q_q;
        BUSY   = (state_q == GRANT);
    end

endmodule
